// File: rtl/wshb_frame_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : video_pkg
// Types and default constants shared by the frame reader and the VGA stage.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package video_pkg;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int WORD_BYTES = 4;

  // Bits [23:0] carry RGB; the top byte is ignored downstream.
  typedef logic [31:0] pixel_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wshb_frame_reader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : wshb_frame_reader_if
// Wishbone classic read bus between the frame reader and the SDRAM slave.
// Rev       : 1.0
// ----------------------------------------------------------------------------
interface wshb_frame_reader_if;
  import video_pkg::*;

  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  pixel_word_t dat_sm;
  logic        ack;

  modport master (
    output adr, cyc, stb, we, sel, cti, bte,
    input  dat_sm, ack
  );

  modport slave (
    input  adr, cyc, stb, we, sel, cti, bte,
    output dat_sm, ack
  );

endinterface
`default_nettype wire

// File: rtl/wshb_frame_reader_pix_addr_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : pix_addr_counter
// Wrapping raster pixel index with a matching registered byte address.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module pix_addr_counter
  import video_pkg::*;
#(
  parameter int          HDISP     = DEF_HDISP,
  parameter int          VDISP     = DEF_VDISP,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         C_IDX_W   = (HDISP * VDISP > 1) ? $clog2(HDISP * VDISP) : 1
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               clr,
  input  wire logic               inc,
  output logic      [C_IDX_W-1:0] idx,
  output logic      [31:0]        adr,
  output logic                    wrap
);

  localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(HDISP * VDISP - 1);

  logic [C_IDX_W-1:0] r_idx;
  logic [31:0]        r_adr;

  assign wrap = inc && (r_idx == C_LAST);

  // Address tracks the index incrementally so no multiplier is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_adr <= BASE_ADDR;
    end else if (clr || wrap) begin
      r_idx <= '0;
      r_adr <= BASE_ADDR;
    end else if (inc) begin
      r_idx <= r_idx + 1'b1;
      r_adr <= r_adr + 32'(WORD_BYTES);
    end
  end

  assign idx = r_idx;
  assign adr = r_adr;

endmodule
`default_nettype wire

// File: rtl/wshb_frame_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : wshb_frame_reader
// Wishbone classic read master streaming the framebuffer into the pixel FIFO.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module wshb_frame_reader
  import video_pkg::*;
#(
  parameter int          HDISP     = DEF_HDISP,
  parameter int          VDISP     = DEF_VDISP,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  wire logic           wshb_clk,
  input  wire logic           wshb_rst_n,
  input  wire logic           enable,
  wshb_frame_reader_if.master wshb,
  output pixel_word_t         fifo_wdata,
  output logic                fifo_write,
  input  wire logic           fifo_afull,
  output logic                frame_start
);

  localparam int C_IDX_W = (HDISP * VDISP > 1) ? $clog2(HDISP * VDISP) : 1;

  state_t             r_state;
  state_t             w_next;
  logic               w_read;
  logic               w_acc;
  logic               w_clr;
  logic               w_wrap_unused;
  logic               r_frame_start;
  logic [C_IDX_W-1:0] w_idx;
  logic [31:0]        w_adr;

  assign w_acc = wshb.ack & w_read;
  // Rewind whenever disabled, except while an access is still awaiting its ack.
  assign w_clr = ~enable & ((r_state != READ) | w_acc);

  pix_addr_counter #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .BASE_ADDR (BASE_ADDR)
  ) u_cnt (
    .clk   (wshb_clk),
    .rst_n (wshb_rst_n),
    .clr   (w_clr),
    .inc   (w_acc),
    .idx   (w_idx),
    .adr   (w_adr),
    .wrap  (w_wrap_unused)
  );

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable && !fifo_afull) w_next = READ;
      READ: begin
        if (w_acc) begin
          if (!enable)        w_next = IDLE;
          else if (fifo_afull) w_next = PAUSE;
        end
      end
      PAUSE: begin
        if (!enable)          w_next = IDLE;
        else if (!fifo_afull) w_next = READ;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_read = (r_state == READ);
  end

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) r_frame_start <= 1'b0;
    else             r_frame_start <= w_acc && (w_idx == '0);
  end

  assign wshb.adr = w_adr;
  assign wshb.cyc = w_read;
  assign wshb.stb = w_read;
  assign wshb.we  = 1'b0;
  assign wshb.sel = 4'b1111;
  assign wshb.cti = 3'b000;
  assign wshb.bte = 2'b00;

  assign fifo_write  = w_acc;
  assign fifo_wdata  = w_acc ? wshb.dat_sm : '0;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_wshb_frame_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_wshb_frame_reader
// Directed self-checking bench: 4x2 frame at 0x100, slave returns data=address.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wshb_frame_reader;
  import video_pkg::*;

  localparam logic [31:0] C_BASE = 32'h100;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        enable     = 1'b0;
  logic        fifo_afull = 1'b0;
  pixel_word_t fifo_wdata;
  logic        fifo_write;
  logic        frame_start;

  wshb_frame_reader_if bus ();

  int          n_tests = 0;
  int          n_fail  = 0;
  int          slv_delay = 1;
  logic        comb_mode = 1'b0;
  logic        spur_ack  = 1'b0;
  logic        r_ack     = 1'b0;
  logic [31:0] r_dat     = '0;
  int          cnt       = 0;
  bit          ok;
  logic [31:0] d;
  logic [31:0] a;

  always #5 clk = ~clk;

  // Slave: acks slv_delay edges after it sees stb, returning the address as data.
  always @(posedge clk) begin
    if (bus.cyc && bus.stb && !r_ack) begin
      if (cnt >= slv_delay - 1) begin
        r_ack <= 1'b1;
        r_dat <= bus.adr;
        cnt   <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      r_ack <= 1'b0;
      cnt   <= 0;
    end
  end

  assign bus.ack    = comb_mode ? (bus.cyc & bus.stb) : (r_ack | spur_ack);
  assign bus.dat_sm = comb_mode ? bus.adr : r_dat;

  wshb_frame_reader #(
    .HDISP     (4),
    .VDISP     (2),
    .BASE_ADDR (C_BASE)
  ) dut (
    .wshb_clk    (clk),
    .wshb_rst_n  (rst_n),
    .enable      (enable),
    .wshb        (bus),
    .fifo_wdata  (fifo_wdata),
    .fifo_write  (fifo_write),
    .fifo_afull  (fifo_afull),
    .frame_start (frame_start)
  );

  task automatic wait_write(output bit found, output logic [31:0] data, output logic [31:0] adr);
    found = 1'b0; data = '0; adr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_write === 1'b1) begin
        found = 1'b1; data = fifo_wdata; adr = bus.adr;
        break;
      end
    end
  endtask

  task automatic wait_access(input logic [31:0] at, input bit with_write, output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cyc === 1'b1 && bus.adr === at && fifo_write === with_write) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    enable = 1'b0; fifo_afull = 1'b0; spur_ack = 1'b0; comb_mode = 1'b0; slv_delay = 1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.cyc, bus.stb, fifo_write, frame_start} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.cyc, bus.stb, fifo_write, frame_start});
    end
    n_tests++;
    if (bus.adr !== C_BASE) begin n_fail++; $display("FAIL reset_adr: got %h want %h", bus.adr, C_BASE); end
    n_tests++;
    if (fifo_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", fifo_wdata); end
    n_tests++;
    if ({bus.we, bus.sel, bus.cti, bus.bte} !== {1'b0, 4'hF, 3'b000, 2'b00}) begin
      n_fail++; $display("FAIL bus_consts: got %b want 0111100000", {bus.we, bus.sel, bus.cti, bus.bte});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [31:0] exp;
    @(negedge clk);
    enable = 1'b1;
    n_tests++;
    if (bus.cyc !== 1'b0) begin n_fail++; $display("FAIL cyc_before_edge: got %b want 0", bus.cyc); end
    @(negedge clk);
    n_tests++;
    if ({bus.cyc, bus.stb} !== 2'b11 || bus.adr !== C_BASE) begin
      n_fail++; $display("FAIL first_access: got cyc/stb %b adr %h want 11 %h", {bus.cyc, bus.stb}, bus.adr, C_BASE);
    end
    for (int i = 0; i < 9; i++) begin
      exp = C_BASE + 32'(4 * (i % 8));
      wait_write(ok, d, a);
      n_tests++;
      if (!ok || d !== exp || a !== exp) begin
        n_fail++; $display("FAIL frame_word%0d: got ok=%0d data %h adr %h want %h", i, ok, d, a, exp);
      end
      if (i == 1) begin
        n_tests++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_idle: got %b want 0", frame_start); end
      end
      if (i == 0 || i == 8) begin
        @(negedge clk);
        n_tests++;
        if (frame_start !== 1'b1) begin n_fail++; $display("FAIL frame_start_pulse%0d: got %b want 1", i, frame_start); end
      end
    end
  endtask

  task automatic test_afull_pause();
    bit stayed;
    do_reset();
    enable = 1'b1;
    wait_access(C_BASE + 32'h8, 1'b0, ok);
    fifo_afull = 1'b1;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== 32'h108) begin n_fail++; $display("FAIL afull_inflight: got ok=%0d data %h want 108", ok, d); end
    @(negedge clk);
    n_tests++;
    if (bus.cyc !== 1'b0 || bus.adr !== 32'h10C) begin
      n_fail++; $display("FAIL afull_pause: got cyc %b adr %h want 0 10c", bus.cyc, bus.adr);
    end
    stayed = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.cyc !== 1'b0 || fifo_write !== 1'b0) stayed = 1'b0;
    end
    n_tests++;
    if (!stayed) begin n_fail++; $display("FAIL afull_hold: got activity while paused, want none"); end
    fifo_afull = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.cyc !== 1'b1 || bus.adr !== 32'h10C) begin
      n_fail++; $display("FAIL afull_resume: got cyc %b adr %h want 1 10c", bus.cyc, bus.adr);
    end
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== 32'h10C) begin n_fail++; $display("FAIL afull_next_word: got ok=%0d data %h want 10c", ok, d); end
  endtask

  task automatic test_slow_ack();
    int  waits;
    int  nw;
    bit  stable;
    bit  wrote;
    do_reset();
    slv_delay = 4;
    enable    = 1'b1;
    waits = 0; stable = 1'b1; wrote = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fifo_write === 1'b1) begin wrote = 1'b1; d = fifo_wdata; break; end
      if (bus.cyc === 1'b1) begin
        waits++;
        if (bus.stb !== 1'b1 || bus.adr !== C_BASE) stable = 1'b0;
      end
    end
    n_tests++;
    if (!wrote || d !== C_BASE) begin n_fail++; $display("FAIL slow_word: got wrote=%0d data %h want 100", wrote, d); end
    n_tests++;
    if (waits !== 4) begin n_fail++; $display("FAIL slow_wait_cycles: got %0d want 4", waits); end
    n_tests++;
    if (!stable) begin n_fail++; $display("FAIL slow_stable: stb/adr moved before ack, want stable"); end
    nw = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (fifo_write === 1'b1) begin nw++; d = fifo_wdata; end
    end
    n_tests++;
    if (nw !== 1 || d !== 32'h104) begin n_fail++; $display("FAIL slow_one_write: got %0d writes data %h want 1 104", nw, d); end
  endtask

  task automatic test_enable_drop();
    bit idle;
    do_reset();
    enable = 1'b1;
    wait_access(C_BASE + 32'h10, 1'b0, ok);
    enable = 1'b0;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== 32'h110) begin n_fail++; $display("FAIL disable_inflight: got ok=%0d data %h want 110", ok, d); end
    @(negedge clk);
    n_tests++;
    if (bus.cyc !== 1'b0 || bus.adr !== C_BASE) begin
      n_fail++; $display("FAIL disable_rewind: got cyc %b adr %h want 0 100", bus.cyc, bus.adr);
    end
    idle = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.cyc !== 1'b0) idle = 1'b0;
    end
    n_tests++;
    if (!idle) begin n_fail++; $display("FAIL disable_idle: got cyc high while disabled, want 0"); end
    enable = 1'b1;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== C_BASE) begin n_fail++; $display("FAIL reenable_restart: got ok=%0d data %h want 100", ok, d); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    enable = 1'b1;
    wait_access(C_BASE + 32'h14, 1'b1, ok);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.cyc, bus.stb, fifo_write} !== 3'b000 || bus.adr !== C_BASE) begin
      n_fail++; $display("FAIL async_reset: got cyc/stb/write %b adr %h want 000 100", {bus.cyc, bus.stb, fifo_write}, bus.adr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== C_BASE) begin n_fail++; $display("FAIL reset_restart: got ok=%0d data %h want 100", ok, d); end
  endtask

  task automatic test_spurious_ack();
    bit quiet;
    do_reset();
    spur_ack = 1'b1;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (fifo_write !== 1'b0 || bus.cyc !== 1'b0 || bus.adr !== C_BASE) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin n_fail++; $display("FAIL spurious_ack: got write/advance, want none"); end
    spur_ack = 1'b0;
    enable   = 1'b1;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== C_BASE) begin n_fail++; $display("FAIL spurious_then_start: got ok=%0d data %h want 100", ok, d); end
  endtask

  task automatic test_last_pixel_pause();
    do_reset();
    enable = 1'b1;
    wait_access(C_BASE + 32'h1C, 1'b0, ok);
    fifo_afull = 1'b1;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== 32'h11C) begin n_fail++; $display("FAIL last_word: got ok=%0d data %h want 11c", ok, d); end
    @(negedge clk);
    n_tests++;
    if (bus.cyc !== 1'b0 || bus.adr !== C_BASE) begin
      n_fail++; $display("FAIL last_wrap_pause: got cyc %b adr %h want 0 100", bus.cyc, bus.adr);
    end
    fifo_afull = 1'b0;
    wait_write(ok, d, a);
    n_tests++;
    if (!ok || d !== C_BASE) begin n_fail++; $display("FAIL wrap_resume: got ok=%0d data %h want 100", ok, d); end
    @(negedge clk);
    n_tests++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_start: got %b want 1", frame_start); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    comb_mode = 1'b1;
    enable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = C_BASE + 32'(4 * (i % 8));
      @(negedge clk);
      n_tests++;
      if (fifo_write !== 1'b1 || fifo_wdata !== exp) begin
        n_fail++; $display("FAIL b2b_word%0d: got write %b data %h want 1 %h", i, fifo_write, fifo_wdata, exp);
      end
    end
    comb_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_afull_pause();
    test_slow_ack();
    test_enable_drop();
    test_reset_mid_access();
    test_spurious_ack();
    test_last_pixel_pause();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within time limit, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
